// File: rtl/input_cmd_pkg.sv
// input_cmd_pkg: shared state encoding and counter sizing for the user-control front-end.
package input_cmd_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, RPT} rpt_state_t;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/input_cmd_ctrl_key_chan.sv
// key_chan: one control line, covering the synchroniser, debounce and auto-repeat command FSM.
module key_chan
    import input_cmd_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int REP_DELAY  = 50_000_000,
    parameter int REP_PERIOD = 10_000_000
)(
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic rep_en,
    output logic level,
    output logic pulse
);

    localparam int DW = cnt_w(DEB_CYCLES);
    localparam int TW = cnt_w(REP_DELAY > REP_PERIOD ? REP_DELAY : REP_PERIOD);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LD  = TW'(REP_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LD = TW'(REP_PERIOD - 1);

    logic [1:0]    sync;
    logic          s;
    logic [DW-1:0] deb_cnt;
    logic          level_nxt;
    logic          rise;
    logic          fall;
    rpt_state_t    state;
    rpt_state_t    state_nxt;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_nxt;
    logic          pulse_nxt;

    assign s         = sync[1];
    assign level_nxt = (s != level && deb_cnt == DEB_LAST) ? ~level : level;
    assign rise      = level_nxt & ~level;
    assign fall      = ~level_nxt & level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= '0;
            deb_cnt <= '0;
            level   <= 1'b0;
        end else begin
            sync    <= {sync[0], raw};
            level   <= level_nxt;
            deb_cnt <= (s == level || level_nxt != level) ? '0 : deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            pulse <= pulse_nxt;
        end
    end

    // An expired HOLD timer with repeat disabled stays frozen at zero until release.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = HOLD;
                    tmr_nxt   = DELAY_LD;
                end
            end
            HOLD: begin
                if (fall) state_nxt = IDLE;
                else if (tmr != '0) tmr_nxt = tmr - 1'b1;
                else if (rep_en) begin
                    state_nxt = RPT;
                    tmr_nxt   = PERIOD_LD;
                end
            end
            RPT: begin
                if (fall) state_nxt = IDLE;
                else if (tmr != '0) tmr_nxt = tmr - 1'b1;
                else if (rep_en) tmr_nxt = PERIOD_LD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pulse_nxt = (state == IDLE) ? rise : (!fall && tmr == '0 && rep_en);
    end

endmodule

// File: rtl/input_cmd_ctrl.sv
// input_cmd_ctrl: debounced command pulses for the board switches/buttons plus the saturating zoom register.
module input_cmd_ctrl
    import input_cmd_pkg::*;
#(
    parameter int N_CH       = 16,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int REP_DELAY  = 50_000_000,
    parameter int REP_PERIOD = 10_000_000,
    parameter int ZIN_CH     = 13,
    parameter int ZOUT_CH    = 12,
    parameter int ZOOM_STEP  = 8,
    parameter int ZOOM_MIN   = 8,
    parameter int ZOOM_MAX   = 128
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pulse,
    output logic [7:0]      visi_cell_num
);

    localparam logic [8:0] STEP = 9'(ZOOM_STEP);
    localparam logic [8:0] VMIN = 9'(ZOOM_MIN);
    localparam logic [8:0] VMAX = 9'(ZOOM_MAX);

    logic [8:0] v9;
    logic [7:0] zoom_up;
    logic [7:0] zoom_dn;
    logic       zin;
    logic       zout;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        key_chan #(
            .DEB_CYCLES(DEB_CYCLES),
            .REP_DELAY (REP_DELAY),
            .REP_PERIOD(REP_PERIOD)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_in[i]),
            .rep_en(repeat_en[i]),
            .level (level[i]),
            .pulse (pulse[i])
        );
    end

    // Saturation is decided in 9 bits so neither bound can wrap the 8-bit register.
    assign v9      = {1'b0, visi_cell_num};
    assign zoom_up = (v9 + STEP > VMAX) ? 8'(VMAX) : 8'(v9 + STEP);
    assign zoom_dn = (v9 < VMIN + STEP) ? 8'(VMIN) : 8'(v9 - STEP);
    assign zin     = pulse[ZIN_CH];
    assign zout    = pulse[ZOUT_CH];

    always_ff @(posedge clk) begin
        if (rst) visi_cell_num <= 8'(VMIN);
        else if (zin && !zout) visi_cell_num <= zoom_up;
        else if (zout && !zin) visi_cell_num <= zoom_dn;
    end

endmodule

// File: tb/tb_input_cmd_ctrl.sv
// tb_input_cmd_ctrl: scoreboard bench for press/bounce/repeat/zoom/reset behaviour of input_cmd_ctrl.
module tb_input_cmd_ctrl;

    localparam int N_CH = 16;
    localparam int ZIN  = 13;
    localparam int ZOUT = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] raw_in = '0;
    logic [N_CH-1:0] repeat_en = '0;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] pulse;
    logic [7:0]      visi_cell_num;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int zoom_m = 8;
    int exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    input_cmd_ctrl #(
        .N_CH      (N_CH),
        .DEB_CYCLES(4),
        .REP_DELAY (10),
        .REP_PERIOD(3),
        .ZIN_CH    (ZIN),
        .ZOUT_CH   (ZOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_in       (raw_in),
        .repeat_en    (repeat_en),
        .level        (level),
        .pulse        (pulse),
        .visi_cell_num(visi_cell_num)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulses are keyed as cycle*32+channel; simultaneous pulses pop in ascending channel order.
    always @(negedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (pulse[i]) begin
                if (exp_q.size() == 0) check("pulse_unexp", cyc * 32 + i, -1);
                else check("pulse", cyc * 32 + i, exp_q.pop_front());
            end
        end
    end

    task automatic press(input logic [N_CH-1:0] m);
        for (int i = 0; i < N_CH; i++)
            if (m[i]) exp_q.push_back((cyc + 6) * 32 + i);
        raw_in = raw_in | m;
        if (m[ZIN] && !m[ZOUT]) zoom_m = (zoom_m + 8 > 128) ? 128 : zoom_m + 8;
        else if (m[ZOUT] && !m[ZIN]) zoom_m = (zoom_m - 8 < 8) ? 8 : zoom_m - 8;
        wait_cyc(8);
        check("zoom", int'(visi_cell_num), zoom_m);
        raw_in = raw_in & ~m;
        wait_cyc(8);
    endtask

    initial begin
        int c;
        logic [N_CH-1:0] m_in;
        logic [N_CH-1:0] m_out;
        m_in  = '0;
        m_out = '0;
        m_in[ZIN]   = 1'b1;
        m_out[ZOUT] = 1'b1;
        wait_cyc(3);
        check("rst_level", int'(level), 0);
        check("rst_pulse", int'(pulse), 0);
        check("rst_zoom", int'(visi_cell_num), 8);
        rst = 1'b0;
        wait_cyc(2);
        // clean press on channel 0, no repeat
        c = cyc;
        exp_q.push_back((c + 6) * 32);
        raw_in[0] = 1'b1;
        wait_cyc(5);
        check("s1_lvl_pre", int'(level[0]), 0);
        wait_cyc(1);
        check("s1_lvl_rise", int'(level[0]), 1);
        check("s1_pulse_hi", int'(pulse[0]), 1);
        wait_cyc(1);
        check("s1_pulse_lo", int'(pulse[0]), 0);
        wait_cyc(13);
        raw_in[0] = 1'b0;
        wait_cyc(10);
        check("s1_lvl_fall", int'(level[0]), 0);
        check("s1_queue", exp_q.size(), 0);
        // bounce shorter than the debounce window
        for (int k = 0; k < 10; k++) begin
            raw_in[0] = ~raw_in[0];
            wait_cyc(2);
            check("s2_bounce", int'(level[0]), 0);
        end
        wait_cyc(8);
        check("s2_lvl", int'(level[0]), 0);
        // auto-repeat on channel 1
        repeat_en[1] = 1'b1;
        c = cyc;
        exp_q.push_back((c + 6) * 32 + 1);
        for (int t = 16; t < 36; t += 3) exp_q.push_back((c + t) * 32 + 1);
        raw_in[1] = 1'b1;
        wait_cyc(30);
        raw_in[1] = 1'b0;
        wait_cyc(5);
        check("s3_lvl_held", int'(level[1]), 1);
        wait_cyc(1);
        check("s3_lvl_fall", int'(level[1]), 0);
        wait_cyc(8);
        check("s3_queue", exp_q.size(), 0);
        // zoom saturation both ways
        repeat (20) press(m_in);
        check("s4_max", int'(visi_cell_num), 128);
        repeat (20) press(m_out);
        check("s4_min", int'(visi_cell_num), 8);
        // simultaneous zoom in/out at 64
        repeat (7) press(m_in);
        check("s5_pre", int'(visi_cell_num), 64);
        press(m_in | m_out);
        check("s5_post", int'(visi_cell_num), 64);
        check("s5_queue", exp_q.size(), 0);
        // reset mid-hold with the line still held
        c = cyc;
        exp_q.push_back((c + 6) * 32 + 1);
        exp_q.push_back((c + 16) * 32 + 1);
        raw_in[1] = 1'b1;
        wait_cyc(17);
        rst = 1'b1;
        wait_cyc(1);
        check("s6_rst_level", int'(level), 0);
        check("s6_rst_pulse", int'(pulse), 0);
        check("s6_rst_zoom", int'(visi_cell_num), 8);
        rst = 1'b0;
        zoom_m = 8;
        exp_q.push_back((cyc + 6) * 32 + 1);
        wait_cyc(5);
        check("s6_lvl_pre", int'(level[1]), 0);
        wait_cyc(1);
        check("s6_lvl_rise", int'(level[1]), 1);
        wait_cyc(2);
        raw_in[1] = 1'b0;
        wait_cyc(10);
        check("s6_lvl_fall", int'(level[1]), 0);
        check("s6_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
